// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C command arbiter and its work-clock divider.
package i2c_arb_pkg;

  localparam int unsigned I2C_DATA_W = 24;
  localparam int unsigned RETRY_W    = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    GAP        = 3'd4,
    FINISH     = 3'd5
  } arb_state_e;

  // Divider terminal count; clamped to 1 so a bad frequency pair cannot stall the tick.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned i2c_freq);
    int unsigned d;
    if (i2c_freq == 0) begin
      d = 1;
    end else begin
      d = clk_freq / i2c_freq;
    end
    if (d == 0) begin
      d = 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_clk_div.sv
// Controller work-clock divider: counts 0..DIV, toggles the work clock on wrap,
// and flags the iCLK cycle whose edge raises the work clock.
module i2c_clk_div #(
  parameter int unsigned DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  output logic ctrl_clk,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_clk_q, ctrl_clk_d;
  logic             wrap_c;

  assign wrap_c = (cnt_q == CNT_W'(DIV));

  // Next counter value and work-clock level.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    ctrl_clk_d = ctrl_clk_q;
    if (wrap_c) begin
      cnt_d      = '0;
      ctrl_clk_d = ~ctrl_clk_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ctrl_clk_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ctrl_clk_q <= ctrl_clk_d;
    end
  end

  assign ctrl_clk = ctrl_clk_q;
  assign tick_c   = wrap_c & ~ctrl_clk_q;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C write controller between NUM_REQ requesters,
// with NACK retry, per-attempt timeout and per-requester done/error reporting.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned I2C_FREQ      = 20000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [NUM_REQ-1:0]      iREQ,
  input  logic [24*NUM_REQ-1:0]   iREQ_DATA,
  output logic [NUM_REQ-1:0]      oGNT,
  output logic [NUM_REQ-1:0]      oDONE,
  output logic                    oERR,
  output logic                    oBUSY,
  output logic                    oI2C_CTRL_CLK,
  output logic                    oI2C_GO,
  output logic [23:0]             oI2C_DATA,
  input  logic                    iI2C_END,
  input  logic                    iI2C_ACK
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, I2C_FREQ);
  localparam int unsigned PTR_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 2);

  logic tick_c;

  arb_state_e              state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    go_q, go_d;
  logic [I2C_DATA_W-1:0]   data_q, data_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [PTR_W-1:0]        sel_q, sel_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    fail_q, fail_d;

  logic                    found_c;
  logic [PTR_W-1:0]        pick_c;
  logic [TO_W-1:0]         to_inc_c;
  logic                    to_expired_c;
  logic [PTR_W-1:0]        rr_next_c;
  logic [I2C_DATA_W-1:0]   req_data_a [NUM_REQ];

  // Work clock and FSM advance strobe.
  i2c_clk_div #(
    .DIV (DIV)
  ) u_clk_div (
    .clk      (iCLK),
    .rst      (iRST),
    .ctrl_clk (oI2C_CTRL_CLK),
    .tick_c   (tick_c)
  );

  // Per-requester view of the packed command bus.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_data
    assign req_data_a[gi] = iREQ_DATA[24*gi +: 24];
  end

  // Round-robin pick: first pending requester at or after the pointer.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = rr_q;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found_c && iREQ[PTR_W'(idx)]) begin
        found_c = 1'b1;
        pick_c  = PTR_W'(idx);
      end
    end
  end

  assign to_inc_c     = to_q + TO_W'(1);
  assign to_expired_c = (to_inc_c >= TO_W'(TIMEOUT_TICKS));
  assign rr_next_c    = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + PTR_W'(1);

  // Transaction sequencer: advances on work-clock ticks; done/err pulse for one iCLK.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    go_d    = go_q;
    data_d  = data_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    retry_d = retry_q;
    to_d    = to_q;
    fail_d  = fail_q;

    // Grant and busy stay up through the done cycle, then release.
    if (done_q != '0) begin
      gnt_d  = '0;
      busy_d = 1'b0;
    end

    if (tick_c) begin
      case (state_q)
        IDLE: begin
          if (found_c) begin
            gnt_d         = '0;
            gnt_d[pick_c] = 1'b1;
            sel_d         = pick_c;
            data_d        = req_data_a[pick_c];
            busy_d        = 1'b1;
            fail_d        = 1'b0;
            retry_d       = '0;
            state_d       = LAUNCH;
          end
        end

        LAUNCH: begin
          go_d    = 1'b1;
          to_d    = '0;
          state_d = WAIT_START;
        end

        WAIT_START: begin
          to_d = to_inc_c;
          if (to_expired_c) begin
            go_d    = 1'b0;
            fail_d  = 1'b1;
            state_d = FINISH;
          end else if (!iI2C_END) begin
            state_d = WAIT_END;
          end
        end

        WAIT_END: begin
          if (iI2C_END) begin
            go_d = 1'b0;
            if (!iI2C_ACK) begin
              fail_d  = 1'b0;
              state_d = FINISH;
            end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = GAP;
            end else begin
              fail_d  = 1'b1;
              state_d = FINISH;
            end
          end else if (to_expired_c) begin
            to_d    = to_inc_c;
            go_d    = 1'b0;
            fail_d  = 1'b1;
            state_d = FINISH;
          end else begin
            to_d = to_inc_c;
          end
        end

        GAP: begin
          state_d = LAUNCH;
        end

        FINISH: begin
          done_d[sel_q] = 1'b1;
          err_d         = fail_q;
          rr_d          = rr_next_c;
          retry_d       = '0;
          state_d       = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer registers; reset drops GO and grant immediately.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      data_q  <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
      retry_q <= '0;
      to_q    <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      fail_q  <= fail_d;
    end
  end

  assign oGNT      = gnt_q;
  assign oDONE     = done_q;
  assign oERR      = err_q;
  assign oBUSY     = busy_q;
  assign oI2C_GO   = go_q;
  assign oI2C_DATA = data_q;

endmodule
